// File: rtl/sample_sender.sv
// sample_sender: FIFO-buffered sample handoff to a core over a dr/modwait handshake.
// Optional macro SAMPLE_SENDER_TIMEOUT_EN bounds WAIT_DONE to 32 cycles (counted as an error).
module sample_sender #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    input  logic              modwait,
    input  logic              err,
    output logic              dr,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              ovf,
    output logic [7:0]        err_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = 5;
    localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(3);
`ifdef SAMPLE_SENDER_TIMEOUT_EN
    localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(31);
`endif
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, DR1, DR2, WAIT_BUSY, WAIT_DONE, REPORT} state_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                tmo_q, tmo_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                dr_q, dr_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   fifo_mem [DEPTH];

    // Next-state, FIFO bookkeeping and registered-output decode
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        tmo_d       = tmo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        err_count_d = err_count_q;
        push        = wr_en & ~full_q;
        pop         = 1'b0;
        // A push while full is lost even if a pop frees a slot this cycle
        ovf_d       = ovf_q | (wr_en & full_q);

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    data_out_d = fifo_mem[rd_ptr_q];
                    state_d    = DR1;
                end
            end
            DR1: state_d = DR2;
            DR2: begin
                state_d = WAIT_BUSY;
                tmr_d   = '0;
                tmo_d   = 1'b0;
            end
            WAIT_BUSY: begin
                if (modwait) begin
                    state_d = WAIT_DONE;
                    tmr_d   = '0;
                end else if (tmr_q == BUSY_LAST) begin
                    state_d = REPORT;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!modwait) begin
                    state_d = REPORT;
`ifdef SAMPLE_SENDER_TIMEOUT_EN
                end else if (tmr_q == DONE_LAST) begin
                    state_d = REPORT;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
`endif
                end
            end
            REPORT: begin
                state_d = IDLE;
                if ((err | tmo_q) && (err_count_q != 8'hFF)) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        full_d  = (cnt_d == CNT_FULL);
        empty_d = (cnt_d == '0);
        dr_d    = (state_d == DR1) || (state_d == DR2);
        done_d  = (state_d == REPORT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            tmo_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            dr_q        <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_count_q <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            dr_q        <= dr_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            err_count_q <= err_count_d;
            data_out_q  <= data_out_d;
        end
    end

    // Sample storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign dr        = dr_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign err_count = err_count_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_sample_sender.sv
// Scoreboard bench for sample_sender with a behavioural core driving modwait/err.
`timescale 1ns/1ps
module tb_sample_sender;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int CORE_NORMAL = 0;
    localparam int CORE_NEVER  = 1;
    localparam int CORE_STUCK  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic              modwait;
    logic              err;
    logic              dr;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              ovf;
    logic [7:0]        err_count;

    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;
    logic [DATA_W-1:0] exp_q [$];
    bit                err_plan [$];
    int core_mode  = CORE_NORMAL;
    int core_delay = 2;
    int core_hold  = 8;
    int cstate;
    int ccnt;
    logic done_prev;

    sample_sender #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .modwait(modwait), .err(err),
        .dr(dr), .data_out(data_out), .done(done), .ovf(ovf), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Core model: registered modwait/err, reacts to dr
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modwait <= 1'b0;
            err     <= 1'b0;
            cstate  <= 0;
            ccnt    <= 0;
        end else begin
            case (cstate)
                0: if (dr) begin
                    if (err_plan.size() > 0) err <= err_plan.pop_front();
                    else err <= 1'b0;
                    ccnt   <= 0;
                    cstate <= (core_mode == CORE_NEVER) ? 3 : 1;
                end
                1: if (ccnt >= core_delay - 1) begin
                    modwait <= 1'b1; ccnt <= 0; cstate <= 2;
                end else ccnt <= ccnt + 1;
                2: if (core_mode != CORE_STUCK) begin
                    if (ccnt >= core_hold - 1) begin
                        modwait <= 1'b0; cstate <= 3;
                    end else ccnt <= ccnt + 1;
                end
                default: if (!dr) cstate <= 0;
            endcase
        end
    end

    // Scoreboard: every done pulse must present the next expected sample
    always @(negedge clk) begin
        if (!reset) begin
            if (done_prev) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_width done=%b exp=0 (second consecutive cycle)", done);
                end
            end
            if (done === 1'b1) begin
                done_pulses++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_done data_out=%h exp=none", data_out);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        miscompares++;
                        $display("FAIL sb_data data_out=%h exp=%h", data_out, e);
                    end
                end
            end
            done_prev <= done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    task automatic push(input logic [DATA_W-1:0] d, input bit acc);
        wr_en   = 1'b1;
        wr_data = d;
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got=%b exp=1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full got=%b exp=0", full); end
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("FAIL rst_dr got=%b exp=0", dr); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got=%b exp=0", done); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rst_errcnt got=%0d exp=0", err_count); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rst_data got=%h exp=0", data_out); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("FAIL idle_dr got=%b exp=0", dr); end
    endtask

    task automatic test_single();
        int base = done_pulses;
        int dr_cycles = 0;
        int n = 0;
        bit seen = 0;
        bit started = 0;
        core_mode = CORE_NORMAL; core_delay = 2; core_hold = 8;
        push(16'h0005, 1'b1);
        while (!seen && n < 80) begin
            if (dr) dr_cycles++;
            if (dr || started) begin
                started = 1;
                vectors++;
                if (data_out !== 16'h0005) begin
                    miscompares++; $display("FAIL single_data_stable got=%h exp=0005", data_out);
                end
            end
            if (done) seen = 1;
            else @(negedge clk);
            n++;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL single_done_timeout got=0 exp=1"); end
        vectors++; if (dr_cycles != 2) begin miscompares++; $display("FAIL single_dr_cycles got=%0d exp=2", dr_cycles); end
        repeat (3) @(negedge clk);
        vectors++; if (done_pulses - base != 1) begin miscompares++; $display("FAIL single_done_count got=%0d exp=1", done_pulses - base); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL single_errcnt got=%0d exp=0", err_count); end
    endtask

    task automatic test_overflow();
        int base = done_pulses;
        int n = 0;
        core_mode = CORE_STUCK; core_delay = 2;
        push(16'h00A0, 1'b1);
        while (!modwait && n < 20) begin @(negedge clk); n++; end
        vectors++; if (modwait !== 1'b1) begin miscompares++; $display("FAIL ovf_core_busy got=%b exp=1", modwait); end
        repeat (2) @(negedge clk);
        push(16'h1111, 1'b1); push(16'h2222, 1'b1); push(16'h3333, 1'b1);
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL ovf_full_at3 got=%b exp=0", full); end
        push(16'h4444, 1'b1);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full_at4 got=%b exp=1", full); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_early got=%b exp=0", ovf); end
        push(16'h5555, 1'b0);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full_after5 got=%b exp=1", full); end
        core_mode = CORE_NORMAL; core_hold = 8;
        wait_drain(300);
        vectors++; if (done_pulses - base != 5) begin miscompares++; $display("FAIL ovf_done_count got=%0d exp=5", done_pulses - base); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty_end got=%b exp=1", empty); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL ovf_errcnt got=%0d exp=0", err_count); end
    endtask

    task automatic test_err_count();
        int base = done_pulses;
        core_mode = CORE_NORMAL; core_delay = 2; core_hold = 3;
        err_plan.push_back(1'b0); err_plan.push_back(1'b1); err_plan.push_back(1'b0);
        push(16'h0101, 1'b1); push(16'h0202, 1'b1); push(16'h0303, 1'b1);
        wait_drain(200);
        vectors++; if (done_pulses - base != 3) begin miscompares++; $display("FAIL errc_done_count got=%0d exp=3", done_pulses - base); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL errc_value got=%0d exp=1", err_count); end
    endtask

    task automatic test_no_modwait();
        int rise [$];
        int dn [$];
        bit prev_dr = 0;
        int k = 0;
        core_mode = CORE_NEVER;
        push(16'h0A0A, 1'b1); push(16'h0B0B, 1'b1);
        while (dn.size() < 2 && k < 100) begin
            if (dr && !prev_dr) rise.push_back(k);
            if (done) dn.push_back(k);
            prev_dr = dr;
            @(negedge clk);
            k++;
        end
        vectors++;
        if (dn.size() != 2 || rise.size() != 2) begin
            miscompares++; $display("FAIL nomw_transfers got=%0d exp=2", dn.size());
        end else begin
            vectors++; if (dn[0] - rise[0] != 6) begin miscompares++; $display("FAIL nomw_latency1 got=%0d exp=6", dn[0] - rise[0]); end
            vectors++; if (rise[1] - dn[0] != 2) begin miscompares++; $display("FAIL nomw_b2b_gap got=%0d exp=2", rise[1] - dn[0]); end
            vectors++; if (dn[1] - rise[1] != 6) begin miscompares++; $display("FAIL nomw_latency2 got=%0d exp=6", dn[1] - rise[1]); end
        end
        repeat (3) @(negedge clk);
        vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL nomw_errcnt got=%0d exp=3", err_count); end
    endtask

    task automatic test_timeout();
        int base = done_pulses;
        int r = -1;
        int d = -1;
        core_mode = CORE_STUCK; core_delay = 2;
        push(16'h7777, 1'b1);
        for (int k = 0; k < 100 && d < 0; k++) begin
            if (dr && r < 0) r = k;
            if (done) d = k;
            @(negedge clk);
        end
`ifdef SAMPLE_SENDER_TIMEOUT_EN
        vectors++; if (d < 0 || r < 0 || d - r != 36) begin miscompares++; $display("FAIL tmo_latency got=%0d exp=36", d - r); end
        repeat (3) @(negedge clk);
        vectors++; if (err_count !== 8'd4) begin miscompares++; $display("FAIL tmo_errcnt got=%0d exp=4", err_count); end
`else
        vectors++; if (done_pulses != base) begin miscompares++; $display("FAIL tmo_no_done got=%0d exp=0", done_pulses - base); end
        vectors++; if (err_count !== 8'd3) begin miscompares++; $display("FAIL tmo_errcnt got=%0d exp=3", err_count); end
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        core_mode = CORE_STUCK;
        push(16'hBEEF, 1'b0);
        repeat (10) @(negedge clk);
        base = done_pulses;
        #2 reset = 1'b1;
        #1;
        vectors++; if (dr !== 1'b0) begin miscompares++; $display("FAIL rmid_dr got=%b exp=0", dr); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rmid_done got=%b exp=0", done); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rmid_ovf got=%b exp=0", ovf); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rmid_errcnt got=%0d exp=0", err_count); end
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL rmid_data got=%h exp=0", data_out); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rmid_empty got=%b exp=1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rmid_full got=%b exp=0", full); end
        exp_q.delete();
        err_plan.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        core_mode = CORE_NORMAL;
        repeat (10) @(negedge clk);
        vectors++; if (done_pulses != base) begin miscompares++; $display("FAIL rmid_no_done got=%0d exp=0", done_pulses - base); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rmid_empty_after got=%b exp=1", empty); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rmid_errcnt_after got=%0d exp=0", err_count); end
    endtask

    task automatic test_saturate();
        int base = done_pulses;
        int sent = 0;
        int n = 0;
        core_mode = CORE_NORMAL; core_delay = 1; core_hold = 1;
        for (int i = 0; i < 256; i++) err_plan.push_back(1'b1);
        while (sent < 256 && n < 4000) begin
            if (!full) begin
                push(16'(sent), 1'b1);
                sent++;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        vectors++; if (sent != 256) begin miscompares++; $display("FAIL sat_sent got=%0d exp=256", sent); end
        wait_drain(4000);
        vectors++; if (done_pulses - base != 256) begin miscompares++; $display("FAIL sat_done_count got=%0d exp=256", done_pulses - base); end
        vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL sat_errcnt got=%0d exp=255", err_count); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sat_ovf got=%b exp=0", ovf); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        test_reset();
        test_single();
        test_overflow();
        test_err_count();
        test_no_modwait();
        test_timeout();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sample_sender.md
SAMPLE_SENDER -- requirements
Module: sample_sender

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of sample words.
REQ-002 SHALL have parameter DEPTH, default 4, number of FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  producer push strobe.
REQ-006 SHALL have port wr_data  input  DATA_W  producer sample.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-009 SHALL have port modwait  input  1  core busy flag, registered in the core.
REQ-010 SHALL have port err  input  1  core error flag, registered in the core.
REQ-011 SHALL have port dr  output  1  data-ready to the core.
REQ-012 SHALL have port data_out  output  DATA_W  sample presented to the core.
REQ-013 SHALL have port done  output  1  one-cycle pulse per completed transfer.
REQ-014 SHALL have port ovf  output  1  sticky flag: a push was dropped.
REQ-015 SHALL have port err_count  output  8  saturating count of transfers ending with err=1.

Function
REQ-016 FIFO push SHALL occur when wr_en=1 and full=0; a push while full SHALL be dropped and SHALL set ovf, even if a pop occurs the same cycle.
REQ-017 FSM states SHALL be IDLE, DR1, DR2, WAIT_BUSY, WAIT_DONE, REPORT.
REQ-018 IDLE -> DR1 when empty=0; the head entry SHALL be popped into the data_out register on that edge.
REQ-019 dr SHALL be 1 in DR1 and DR2 only (two cycles, so the core samples dr=1 both in its idle and store states); DR1 -> DR2 -> WAIT_BUSY unconditionally.
REQ-020 WAIT_BUSY -> WAIT_DONE when modwait=1; after 4 cycles in WAIT_BUSY with modwait=0 SHALL go to REPORT and count as an error.
REQ-021 WAIT_DONE -> REPORT when modwait=0.
REQ-022 REPORT SHALL assert done for one cycle, sample err (or the REQ-020 timeout) and increment err_count saturating at 255, then go to IDLE.
REQ-023 data_out SHALL remain stable from DR1 entry until REPORT exit.
REQ-024 Back-to-back: with FIFO non-empty, IDLE lasts exactly one cycle between transfers; minimum transfer period is DR1+DR2+WAIT_BUSY+WAIT_DONE+REPORT+IDLE cycles.
REQ-025 Pointer wrap SHALL be modulo DEPTH; occupancy count SHALL be DEPTH+1 states wide so full/empty are unambiguous.
REQ-026 Push accepted in the same cycle that IDLE sees empty=1 SHALL be launched on the following cycle, not the same one.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, FIFO empty (empty=1, full=0), dr=0, done=0, ovf=0, err_count=0, data_out=0.
REQ-028 reset mid-transfer SHALL abandon the transfer without a done pulse or err_count change.

Configuration
REQ-029 Macro SAMPLE_SENDER_TIMEOUT_EN: when defined, WAIT_DONE SHALL exit to REPORT after 32 cycles with modwait still 1 and count as an error; when undefined, WAIT_DONE waits indefinitely.

Verification
REQ-030 Push 0x0005, core model raises modwait 2 cycles after dr and holds 8 cycles, err=0 -> dr high exactly 2 cycles, data_out=0x0005 throughout, one done pulse, err_count=0.
REQ-031 Push 5 samples into DEPTH=4 with no pops possible (core held busy) -> full=1 after 4, fifth dropped, ovf=1, four transfers later complete in order.
REQ-032 Core returns err=1 on transfer 2 of 3 -> err_count=1 after third done; 256 error transfers -> err_count=255.
REQ-033 Core never raises modwait -> REPORT after 4 WAIT_BUSY cycles, err_count increments, next sample launches.
REQ-034 Assert reset during WAIT_DONE -> all outputs at reset values same cycle, no done pulse, FIFO empty.
REQ-035 With SAMPLE_SENDER_TIMEOUT_EN, modwait stuck at 1 -> done after 32 WAIT_DONE cycles, err_count=1; without it, no done within 100 cycles.
